// File: rtl/stl_uart_pkg.sv
// Shared STL UART definitions: packet geometry, FSM state encodings and
// debug counter limits used by both the host and the client.
package stl_uart_pkg;

   localparam int unsigned STL_PACKET_BYTES = 16;
   localparam int unsigned STL_PACKET_BITS  = 128;

   // Encodings are shared so debug_state decodes the same on both ends.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SEND    = 2'd1,
      ST_RECEIVE = 2'd2,
      ST_DELIVER = 2'd3
   } stl_state_t;

   localparam logic [7:0] DROP_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/stl_timeout_timer.sv
// Idle-cycle timer. Counts ticks since the last clear and flags the tick on
// which the count reaches LIMIT, so the caller can act on that same edge.
// LIMIT = 0 disables the timer entirely.
module stl_timeout_timer #(
   parameter int unsigned LIMIT = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic tick,
   output logic expired
);

   localparam int unsigned W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
   localparam logic [W-1:0] LIMIT_VAL = W'(LIMIT);
   localparam logic [W-1:0] LAST_VAL  = (LIMIT > 0) ? W'(LIMIT - 1) : '0;

   logic [W-1:0] count_reg;

   // Count idle ticks; stop at LIMIT rather than wrapping.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_reg <= '0;
      end else if (tick && (count_reg != LIMIT_VAL)) begin
         count_reg <= count_reg + 1'b1;
      end
   end

   // Flag the tick that takes the count to LIMIT.
   always_comb begin
      expired = (LIMIT != 0) && tick && (count_reg == LAST_VAL);
   end

endmodule

// File: rtl/stl_uart_host.sv
// STL UART host: serializes a 128-bit request into bytes (LSB first),
// then reassembles a 16-byte reply into a 128-bit response, with an
// inter-byte timeout guarding against a silent far end.
module stl_uart_host
   import stl_uart_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ     = 100_000_000,
   parameter int unsigned PACKET_SIZE    = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [STL_PACKET_BITS-1:0] req_data,
   output logic                       tx_valid,
   input  logic                       tx_ready,
   output logic [7:0]                 tx_data,
   input  logic                       rx_valid,
   output logic                       rx_ready,
   input  logic [7:0]                 rx_data,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [STL_PACKET_BITS-1:0] resp_data,
   output logic                       resp_error,
   output logic [1:0]                 debug_state,
   output logic [4:0]                 debug_byte_count,
   output logic [7:0]                 debug_drop_count
);

   // A zero clock frequency is meaningless; treat it as "no timeout"
   // rather than timing against an undefined time base.
   localparam int unsigned TIMER_LIMIT = (CLOCK_FREQ > 0) ? TIMEOUT_CYCLES : 0;
   localparam logic [4:0]  LAST_BYTE   = 5'(PACKET_SIZE - 1);

   stl_state_t                 state_reg, state_next;
   logic [STL_PACKET_BITS-1:0] tx_shift_reg, tx_shift_next;
   logic [STL_PACKET_BITS-1:0] rx_buf_reg, rx_buf_next;
   logic [4:0]                 byte_count_reg, byte_count_next;
   logic                       resp_error_reg, resp_error_next;
   logic [7:0]                 drop_count_reg, drop_count_next;

   logic tx_fire;
   logic rx_fire;
   logic timer_clear;
   logic timer_tick;
   logic timer_expired;

   assign req_ready        = (state_reg == ST_IDLE);
   assign tx_valid         = (state_reg == ST_SEND);
   assign tx_data          = tx_shift_reg[7:0];
   assign rx_ready         = (state_reg != ST_DELIVER);
   assign resp_valid       = (state_reg == ST_DELIVER);
   assign resp_data        = rx_buf_reg;
   assign resp_error       = resp_error_reg;
   assign debug_state      = state_reg;
   assign debug_byte_count = byte_count_reg;
   assign debug_drop_count = drop_count_reg;

   assign tx_fire     = tx_valid && tx_ready;
   assign rx_fire     = rx_valid && rx_ready;
   // The timer only runs while awaiting reply bytes; any accepted byte restarts it.
   assign timer_tick  = (state_reg == ST_RECEIVE) && !rx_fire;
   assign timer_clear = (state_reg != ST_RECEIVE) || rx_fire;

   stl_timeout_timer #(
      .LIMIT(TIMER_LIMIT)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (timer_clear),
      .tick   (timer_tick),
      .expired(timer_expired)
   );

   // State and datapath registers; reset drops any partial packet.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= ST_IDLE;
         tx_shift_reg   <= '0;
         rx_buf_reg     <= '0;
         byte_count_reg <= '0;
         resp_error_reg <= 1'b0;
         drop_count_reg <= '0;
      end else begin
         state_reg      <= state_next;
         tx_shift_reg   <= tx_shift_next;
         rx_buf_reg     <= rx_buf_next;
         byte_count_reg <= byte_count_next;
         resp_error_reg <= resp_error_next;
         drop_count_reg <= drop_count_next;
      end
   end

   // Next-state, byte shifting and stray-byte accounting.
   always_comb begin
      state_next      = state_reg;
      tx_shift_next   = tx_shift_reg;
      rx_buf_next     = rx_buf_reg;
      byte_count_next = byte_count_reg;
      resp_error_next = resp_error_reg;
      drop_count_next = drop_count_reg;

      // Bytes arriving before the request has been fully sent are not part
      // of any reply; count them (saturating) and discard.
      if (rx_fire && ((state_reg == ST_IDLE) || (state_reg == ST_SEND)) &&
          (drop_count_reg != DROP_COUNT_MAX)) begin
         drop_count_next = drop_count_reg + 8'd1;
      end

      case (state_reg)
         ST_IDLE: begin
            if (req_valid) begin
               tx_shift_next   = req_data;
               byte_count_next = '0;
               state_next      = ST_SEND;
            end
         end
         ST_SEND: begin
            if (tx_fire) begin
               tx_shift_next   = tx_shift_reg >> 8;
               byte_count_next = byte_count_reg + 5'd1;
               if (byte_count_reg == LAST_BYTE) begin
                  rx_buf_next     = '0;
                  byte_count_next = '0;
                  state_next      = ST_RECEIVE;
               end
            end
         end
         ST_RECEIVE: begin
            // An arriving byte takes priority over an expiring timer.
            if (rx_fire) begin
               rx_buf_next     = {rx_data, rx_buf_reg[STL_PACKET_BITS-1:8]};
               byte_count_next = byte_count_reg + 5'd1;
               if (byte_count_reg == LAST_BYTE) begin
                  resp_error_next = 1'b0;
                  state_next      = ST_DELIVER;
               end
            end else if (timer_expired) begin
               rx_buf_next     = '0;
               resp_error_next = 1'b1;
               state_next      = ST_DELIVER;
            end
         end
         ST_DELIVER: begin
            if (resp_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_stl_uart_host.sv
// Directed testbench for stl_uart_host with hand-computed expectations.
`timescale 1ns/1ps
module tb_stl_uart_host;

   logic         clk = 1'b0;
   logic         reset;
   logic         req_valid;
   logic         req_ready;
   logic [127:0] req_data;
   logic         tx_valid;
   logic         tx_ready;
   logic [7:0]   tx_data;
   logic         rx_valid;
   logic         rx_ready;
   logic [7:0]   rx_data;
   logic         resp_valid;
   logic         resp_ready;
   logic [127:0] resp_data;
   logic         resp_error;
   logic [1:0]   debug_state;
   logic [4:0]   debug_byte_count;
   logic [7:0]   debug_drop_count;

   int check_count = 0;
   int pass_count  = 0;

   always #5 clk = ~clk;

   stl_uart_host #(
      .CLOCK_FREQ    (100_000_000),
      .PACKET_SIZE   (16),
      .TIMEOUT_CYCLES(100)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_data        (req_data),
      .tx_valid        (tx_valid),
      .tx_ready        (tx_ready),
      .tx_data         (tx_data),
      .rx_valid        (rx_valid),
      .rx_ready        (rx_ready),
      .rx_data         (rx_data),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
      .resp_data       (resp_data),
      .resp_error      (resp_error),
      .debug_state     (debug_state),
      .debug_byte_count(debug_byte_count),
      .debug_drop_count(debug_drop_count)
   );

   // Advance one clock; inputs change and outputs are read 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_request(input logic [127:0] d);
      req_data  = d;
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
   endtask

   task automatic drain_tx();
      tx_ready = 1'b1;
      repeat (16) step();
   endtask

   task automatic feed_rx(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         rx_valid = 1'b1;
         rx_data  = 8'(base + 8'(i));
         step();
      end
      rx_valid = 1'b0;
   endtask

   task automatic consume_resp();
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      check_count++;
      if (req_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 8'h00 || rx_ready !== 1'b1)
         $display("FAIL reset_handshake: req_ready=%b tx_valid=%b tx_data=%h rx_ready=%b, required 1 0 00 1",
                  req_ready, tx_valid, tx_data, rx_ready);
      else pass_count++;
      check_count++;
      if (resp_valid !== 1'b0 || resp_error !== 1'b0 || resp_data !== 128'h0)
         $display("FAIL reset_resp: resp_valid=%b resp_error=%b resp_data=%h, required 0 0 0",
                  resp_valid, resp_error, resp_data);
      else pass_count++;
      check_count++;
      if (debug_state !== 2'd0 || debug_byte_count !== 5'd0 || debug_drop_count !== 8'd0)
         $display("FAIL reset_debug: state=%0d count=%0d drops=%0d, required 0 0 0",
                  debug_state, debug_byte_count, debug_drop_count);
      else pass_count++;
      $display("reset: state=%0d req_ready=%b", debug_state, req_ready);
   endtask

   task automatic test_round_trip();
      logic [7:0] exp_byte;
      tx_ready = 1'b1;
      start_request(128'h0F0E0D0C0B0A09080706050403020100);
      for (int i = 0; i < 16; i++) begin
         exp_byte = 8'(i);
         check_count++;
         if (tx_valid !== 1'b1 || tx_data !== exp_byte)
            $display("FAIL round_trip_tx[%0d]: tx_valid=%b tx_data=%h, required 1 %h",
                     i, tx_valid, tx_data, exp_byte);
         else pass_count++;
         step();
      end
      check_count++;
      if (debug_state !== 2'd2 || tx_valid !== 1'b0)
         $display("FAIL round_trip_receive: state=%0d tx_valid=%b, required 2 0", debug_state, tx_valid);
      else pass_count++;
      feed_rx(8'hA0, 16);
      check_count++;
      if (resp_valid !== 1'b1 || resp_error !== 1'b0 ||
          resp_data !== 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0)
         $display("FAIL round_trip_resp: valid=%b error=%b data=%h, required 1 0 afaeadacabaaa9a8a7a6a5a4a3a2a1a0",
                  resp_valid, resp_error, resp_data);
      else pass_count++;
      check_count++;
      if (req_ready !== 1'b0 || rx_ready !== 1'b0)
         $display("FAIL round_trip_deliver_ready: req_ready=%b rx_ready=%b, required 0 0", req_ready, rx_ready);
      else pass_count++;
      consume_resp();
      check_count++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0)
         $display("FAIL round_trip_idle: req_ready=%b resp_valid=%b, required 1 0", req_ready, resp_valid);
      else pass_count++;
      $display("round_trip: resp_data=%h resp_error=%b", resp_data, resp_error);
   endtask

   task automatic test_tx_backpressure();
      int         hs;
      logic [7:0] exp_byte;
      hs = 0;
      tx_ready = 1'b1;
      start_request(128'h3F3E3D3C3B3A39383736353433323130);
      for (int cyc = 0; cyc < 32; cyc++) begin
         tx_ready = ((cyc % 2) == 0);
         if (tx_valid === 1'b1) begin
            exp_byte = 8'(8'h30 + 8'(hs));
            check_count++;
            if (tx_data !== exp_byte)
               $display("FAIL backpressure_tx cyc %0d: tx_data=%h, required %h", cyc, tx_data, exp_byte);
            else pass_count++;
            if (tx_ready) hs++;
         end
         step();
      end
      check_count++;
      if (hs != 16 || tx_valid !== 1'b0)
         $display("FAIL backpressure_count: handshakes=%0d tx_valid=%b, required 16 0", hs, tx_valid);
      else pass_count++;
      feed_rx(8'h50, 16);
      check_count++;
      if (resp_valid !== 1'b1 || resp_data !== 128'h5F5E5D5C5B5A59585756555453525150)
         $display("FAIL backpressure_resp: valid=%b data=%h, required 1 5f5e5d5c5b5a59585756555453525150",
                  resp_valid, resp_data);
      else pass_count++;
      consume_resp();
      $display("tx_backpressure: handshakes=%0d", hs);
   endtask

   task automatic test_timeout();
      int n;
      start_request(128'h00112233445566778899AABBCCDDEEFF);
      drain_tx();
      feed_rx(8'hC0, 5);
      n = 0;
      for (int k = 1; k <= 150; k++) begin
         step();
         if (resp_valid === 1'b1) begin
            n = k;
            break;
         end
      end
      check_count++;
      if (n != 100)
         $display("FAIL timeout_latency: resp_valid after %0d cycles, required 100", n);
      else pass_count++;
      check_count++;
      if (resp_error !== 1'b1 || resp_data !== 128'h0)
         $display("FAIL timeout_resp: error=%b data=%h, required 1 0", resp_error, resp_data);
      else pass_count++;
      consume_resp();
      check_count++;
      if (req_ready !== 1'b1)
         $display("FAIL timeout_req_ready: req_ready=%b, required 1", req_ready);
      else pass_count++;
      $display("timeout: latency=%0d resp_error=%b", n, resp_error);
   endtask

   task automatic test_stray_bytes();
      reset = 1'b1;
      step();
      reset = 1'b0;
      feed_rx(8'hE0, 3);
      tx_ready = 1'b0;
      start_request(128'hFFEEDDCCBBAA99887766554433221100);
      feed_rx(8'hD0, 2);
      drain_tx();
      check_count++;
      if (debug_drop_count !== 8'd5)
         $display("FAIL stray_drop_count: drops=%0d, required 5", debug_drop_count);
      else pass_count++;
      feed_rx(8'h60, 16);
      check_count++;
      if (resp_valid !== 1'b1 || resp_data !== 128'h6F6E6D6C6B6A69686766656463626160)
         $display("FAIL stray_resp: valid=%b data=%h, required 1 6f6e6d6c6b6a69686766656463626160",
                  resp_valid, resp_data);
      else pass_count++;
      consume_resp();
      feed_rx(8'h00, 300);
      check_count++;
      if (debug_drop_count !== 8'd255)
         $display("FAIL stray_saturation: drops=%0d, required 255", debug_drop_count);
      else pass_count++;
      $display("stray_bytes: drop_count=%0d", debug_drop_count);
   endtask

   task automatic test_resp_hold_and_reset();
      int bad;
      tx_ready = 1'b1;
      start_request(128'h0123456789ABCDEF0123456789ABCDEF);
      drain_tx();
      feed_rx(8'h70, 16);
      resp_ready = 1'b0;
      for (int c = 0; c < 20; c++) begin
         check_count++;
         if (resp_valid !== 1'b1 || resp_error !== 1'b0 ||
             resp_data !== 128'h7F7E7D7C7B7A79787776757473727170)
            $display("FAIL resp_hold cyc %0d: valid=%b error=%b data=%h, required 1 0 7f7e7d7c7b7a79787776757473727170",
                     c, resp_valid, resp_error, resp_data);
         else pass_count++;
         step();
      end
      consume_resp();
      // Abort a request after byte 7 has been handed to the transmitter.
      start_request(128'hCAFEBABEDEADBEEF0011223344556677);
      repeat (8) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_count++;
      if (tx_valid !== 1'b0 || debug_state !== 2'd0 || req_ready !== 1'b1)
         $display("FAIL reset_abort: tx_valid=%b state=%0d req_ready=%b, required 0 0 1",
                  tx_valid, debug_state, req_ready);
      else pass_count++;
      bad = 0;
      for (int c = 0; c < 30; c++) begin
         if (resp_valid !== 1'b0 || tx_valid !== 1'b0) bad++;
         step();
      end
      check_count++;
      if (bad != 0)
         $display("FAIL reset_no_output: %0d cycles with activity, required 0", bad);
      else pass_count++;
      $display("resp_hold_and_reset: state=%0d", debug_state);
   endtask

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_data   = '0;
      tx_ready   = 1'b0;
      rx_valid   = 1'b0;
      rx_data    = '0;
      resp_ready = 1'b0;
      test_reset();
      test_round_trip();
      test_tx_backpressure();
      test_timeout();
      test_stray_bytes();
      test_resp_hold_and_reset();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_count, check_count);
      $fatal(1, "watchdog");
   end

endmodule
